// File: rtl/boot_loader.sv
// boot_loader: program loader and SRAM port mux between CPU and SRAM.
// After reset the CPU is held while a big-endian byte stream (16-bit word
// count N, then N data words) is accepted over rx_valid/rx_ready and
// written to SRAM at BASE_ADDR + idx (mod 2^ADDR_W). Once loaded the CPU
// SRAM port is passed straight through and cpu_hold drops.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   When defined, a 16-bit checksum word (sum of data words mod 2^16)
//   follows the data; a mismatch parks the loader in ERR with err = 1.
//   When undefined, the checksum states are not built and err is tied to 0.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   rx_data/valid/ready   byte stream handshake
//   cpu_addr/din/we       CPU SRAM port (ignored until done)
//   sram_addr/din/we      SRAM port (loader in load phase, CPU when done)
//   cpu_hold              CPU stall request
//   done                  load complete, pass-through active
//   err                   checksum failure
module boot_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_din,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_din,
    output logic              sram_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [3:0] {
        HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, CHK_HI, CHK_LO, DONE, ERR
    } state_t;
    // After the last data word (or an empty header) the checksum follows
    localparam state_t AFTER_DATA = CHK_HI;
`else
    typedef enum logic [3:0] {
        HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, DONE
    } state_t;
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t              state;
    state_t              state_nxt;
    logic                rx_en;
    logic                accept;
    logic [WORD_W-1:0]   n_words;
    logic [WORD_W-1:0]   idx;
    logic [WORD_W-1:0]   idx_inc;
    logic [WORD_W-1:0]   word;
    logic [ADDR_W-1:0]   wr_addr;
`ifdef BOOT_CHECKSUM_EN
    logic [WORD_W-1:0]   csum;
    logic [BYTE_W-1:0]   chk_hi;
`endif

    assign idx_inc = idx + WORD_W'(1);
    assign wr_addr = BASE + ADDR_W'(idx);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HDR_HI;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and port outputs; DONE muxes the CPU port through
    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        accept    = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        cpu_hold  = 1'b1;
        done      = 1'b0;
        err       = 1'b0;

        case (state)
            HDR_HI, HDR_LO, DATA_HI, DATA_LO: rx_ready = rx_en;
`ifdef BOOT_CHECKSUM_EN
            CHK_HI, CHK_LO:                   rx_ready = rx_en;
`endif
            default:                          rx_ready = 1'b0;
        endcase
        accept = rx_valid && rx_ready;

        case (state)
            HDR_HI: begin
                if (accept) state_nxt = HDR_LO;
            end
            HDR_LO: begin
                if (accept) begin
                    state_nxt = ({n_words[15:8], rx_data} == WORD_W'(0)) ? AFTER_DATA : DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) state_nxt = DATA_LO;
            end
            DATA_LO: begin
                if (accept) state_nxt = WRITE;
            end
            WRITE: begin
                sram_we   = 1'b1;
                sram_addr = wr_addr;
                sram_din  = word;
                state_nxt = (idx_inc == n_words) ? AFTER_DATA : DATA_HI;
            end
`ifdef BOOT_CHECKSUM_EN
            CHK_HI: begin
                if (accept) state_nxt = CHK_LO;
            end
            CHK_LO: begin
                if (accept) state_nxt = ({chk_hi, rx_data} == csum) ? DONE : ERR;
            end
            ERR: begin
                err = 1'b1;
            end
`endif
            DONE: begin
                sram_we   = cpu_we;
                sram_addr = cpu_addr;
                sram_din  = cpu_din;
                cpu_hold  = 1'b0;
                done      = 1'b1;
            end
            default: begin
                state_nxt = HDR_HI;
            end
        endcase
    end

    // Byte-enable gate: rx_ready stays low until the first clock after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_en <= 1'b0;
        end else begin
            rx_en <= 1'b1;
        end
    end

    // Header, word assembly and write index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_words <= '0;
            idx     <= '0;
            word    <= '0;
        end else begin
            if (accept) begin
                case (state)
                    HDR_HI:  n_words[15:8] <= rx_data;
                    HDR_LO: begin
                        n_words[7:0] <= rx_data;
                        idx          <= '0;
                    end
                    DATA_HI: word[15:8] <= rx_data;
                    DATA_LO: word[7:0]  <= rx_data;
                    default: ;
                endcase
            end
            if (state == WRITE) begin
                idx <= idx_inc;
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running sum of written data words and the received checksum high byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum   <= '0;
            chk_hi <= '0;
        end else begin
            if (state == WRITE) begin
                csum <= csum + word;
            end
            if (accept && state == CHK_HI) begin
                chk_hi <= rx_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader: two instances (BASE_ADDR 0 and 0xFFE) share one
// byte source; a stream/SRAM-image model built from word lists supplies
// every expected write, plus directed sequences for timing corner cases.
module tb_boot_loader;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [11:0] a;
        logic [15:0] d;
        logic        we;
        logic [11:0] ea;
        logic [15:0] ed;
        logic        ewe;
    } pt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_din;
    logic        cpu_we;

    logic        rx_ready0, sram_we0, cpu_hold0, done0, err0;
    logic [11:0] sram_addr0;
    logic [15:0] sram_din0;
    logic        rx_ready1, sram_we1, cpu_hold1, done1, err1;
    logic [11:0] sram_addr1;
    logic [15:0] sram_din1;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] words[$];
    logic [7:0]  bq[$];
    int          wq[$];
    wr_t         exp0[$], exp1[$], got0[$], got1[$];
    pt_t         tbl[6];

    always #5 clk = ~clk;

    boot_loader #(.ADDR_W(12), .BASE_ADDR(0)) u_dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready0),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .sram_addr(sram_addr0), .sram_din(sram_din0), .sram_we(sram_we0),
        .cpu_hold(cpu_hold0), .done(done0), .err(err0)
    );

    boot_loader #(.ADDR_W(12), .BASE_ADDR(12'hFFE)) u_dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready1),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .sram_addr(sram_addr1), .sram_din(sram_din1), .sram_we(sram_we1),
        .cpu_hold(cpu_hold1), .done(done1), .err(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record every loader-phase SRAM write; the source must be stalled then
    always @(negedge clk) begin
        if (rst && cpu_hold0 && sram_we0) begin
            got0.push_back({sram_addr0, sram_din0});
            check("ready_in_write", 32'(rx_ready0), 32'(0));
        end
        if (rst && cpu_hold1 && sram_we1) begin
            got1.push_back({sram_addr1, sram_din1});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: byte stream and SRAM write list from the word list
    task automatic build();
        int unsigned sum = 0;
        int unsigned n   = words.size();
        bq.delete(); exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
        bq.push_back(8'(n >> 8));
        bq.push_back(8'(n));
        for (int i = 0; i < words.size(); i++) begin
            bq.push_back(words[i][15:8]);
            bq.push_back(words[i][7:0]);
            sum = sum + 32'(words[i]);
            exp0.push_back({12'(i % 4096), words[i]});
            exp1.push_back({12'((4094 + i) % 4096), words[i]});
        end
`ifdef BOOT_CHECKSUM_EN
        bq.push_back(8'(sum >> 8));
        bq.push_back(8'(sum));
`endif
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present one byte after 'idle' empty cycles; waits = edges until accepted
    task automatic send_byte(input logic [7:0] b, input int idle, output int waits);
        bit   acc;
        logic r;
        acc = 1'b0;
        rx_valid = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        rx_data = b;
        rx_valid = 1'b1;
        waits = 0;
        while (!acc && waits < 40) begin
            @(negedge clk);
            r = rx_ready0;
            @(posedge clk);
            #1;
            waits++;
            if (r) acc = 1'b1;
        end
        rx_valid = 1'b0;
        if (!acc) check("rx_timeout", 32'(0), 32'(1));
    endtask

    // mode 0: valid held, 1: valid toggles, 2: random gaps
    task automatic send_stream(input int mode);
        int w;
        int idle;
        wq.delete();
        for (int k = 0; k < bq.size(); k++) begin
            if (mode == 0)      idle = 0;
            else if (mode == 1) idle = 1;
            else                idle = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_byte(bq[k], idle, w);
            wq.push_back(w);
        end
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_done0"}, 32'(done0), 32'(1));
        check({name, "_done1"}, 32'(done1), 32'(1));
    endtask

    task automatic cmp_writes(input string tag);
        check({tag, "_cnt0"}, 32'(got0.size()), 32'(exp0.size()));
        check({tag, "_cnt1"}, 32'(got1.size()), 32'(exp1.size()));
        for (int i = 0; i < exp0.size() && i < got0.size(); i++)
            check({tag, "_wr0"}, 32'(got0[i]), 32'(exp0[i]));
        for (int i = 0; i < exp1.size() && i < got1.size(); i++)
            check({tag, "_wr1"}, 32'(got1[i]), 32'(exp1[i]));
    endtask

    initial begin
        int exp_w[10];
        rst = 1'b0; rx_valid = 1'b0; rx_data = '0;
        cpu_we = 1'b1; cpu_addr = 12'h0A5; cpu_din = 16'h5A5A;

        tbl[0] = '{12'h0A5, 16'h5A5A, 1'b1, 12'h0A5, 16'h5A5A, 1'b1};
        tbl[1] = '{12'h000, 16'h0000, 1'b0, 12'h000, 16'h0000, 1'b0};
        tbl[2] = '{12'hFFF, 16'hFFFF, 1'b1, 12'hFFF, 16'hFFFF, 1'b1};
        tbl[3] = '{12'h123, 16'hBEEF, 1'b0, 12'h123, 16'hBEEF, 1'b0};
        tbl[4] = '{12'h800, 16'h0001, 1'b1, 12'h800, 16'h0001, 1'b1};
        tbl[5] = '{12'h7FF, 16'h8000, 1'b1, 12'h7FF, 16'h8000, 1'b1};
        exp_w = '{1, 1, 1, 1, 2, 1, 2, 1, 2, 1};

        // Reset values, CPU write request ignored
        #2;
        check("rst_ready", 32'(rx_ready0), 32'(0));
        check("rst_we", 32'(sram_we0), 32'(0));
        check("rst_hold", 32'(cpu_hold0), 32'(1));
        check("rst_done", 32'(done0), 32'(0));
        check("rst_err", 32'(err0), 32'(0));
        check("rst_addr", 32'(sram_addr0), 32'(0));
        check("rst_din", 32'(sram_din0), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("en_gate", 32'(rx_ready0), 32'(0));
        @(posedge clk);
        #1;
        check("en_set", 32'(rx_ready0), 32'(1));

        // Basic load with CPU write request held active
        words = '{16'h1234, 16'hABCD, 16'h0001};
        build();
        for (int k = 0; k < bq.size(); k++) begin
            int w;
            send_byte(bq[k], 0, w);
            check("throughput_wait", 32'(w), 32'(exp_w[k]));
            if (k == 3 || k == 5 || k == 7) begin
                check("we_latency", 32'(sram_we0), 32'(1));
                check("we_data", 32'(sram_din0), 32'(words[(k - 3) / 2]));
            end else if (k < 8) begin
                check("we_ignored", 32'(sram_we0), 32'(0));
            end
`ifndef BOOT_CHECKSUM_EN
            if (k == 7) begin
                check("hold_in_last_write", 32'(cpu_hold0), 32'(1));
                @(posedge clk);
                #1;
                check("release_done", 32'(done0), 32'(1));
                check("release_hold", 32'(cpu_hold0), 32'(0));
            end
`else
            if (k == 9) begin
                check("chk_done", 32'(done0), 32'(1));
                check("chk_hold", 32'(cpu_hold0), 32'(0));
            end
`endif
        end
        check("pt_we", 32'(sram_we0), 32'(1));
        check("pt_addr", 32'(sram_addr0), 32'(12'h0A5));
        check("pt_din", 32'(sram_din0), 32'(16'h5A5A));
        check("pt_ready", 32'(rx_ready0), 32'(0));
        cmp_writes("basic");

        // Pass-through table
        for (int i = 0; i < 6; i++) begin
            cpu_addr = tbl[i].a; cpu_din = tbl[i].d; cpu_we = tbl[i].we;
            #1;
            check("tbl_addr0", 32'(sram_addr0), 32'(tbl[i].ea));
            check("tbl_din0", 32'(sram_din0), 32'(tbl[i].ed));
            check("tbl_we0", 32'(sram_we0), 32'(tbl[i].ewe));
            check("tbl_addr1", 32'(sram_addr1), 32'(tbl[i].ea));
            check("tbl_we1", 32'(sram_we1), 32'(tbl[i].ewe));
        end
        cpu_we = 1'b0;

        // Empty load: release on the edge accepting the last stream byte
        do_reset();
        words.delete();
        build();
        for (int k = 0; k < bq.size(); k++) begin
            int w;
            check("empty_hold_before", 32'(cpu_hold0), 32'(1));
            send_byte(bq[k], 0, w);
        end
        check("empty_done", 32'(done0), 32'(1));
        check("empty_hold", 32'(cpu_hold0), 32'(0));
        cmp_writes("empty");

        // Gappy source, valid toggling every cycle
        do_reset();
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back(16'($urandom));
        build();
        send_stream(1);
        wait_done("gappy");
        cmp_writes("gappy");

        // Reset during the second write aborts at once
        do_reset();
        words = '{16'h1122, 16'h3344};
        build();
        for (int k = 0; k < 6; k++) begin
            int w;
            send_byte(bq[k], 0, w);
        end
        check("abort_we_before", 32'(sram_we0), 32'(1));
        rst = 1'b0;
        #1;
        check("abort_we0", 32'(sram_we0), 32'(0));
        check("abort_we1", 32'(sram_we1), 32'(0));
        check("abort_hold", 32'(cpu_hold0), 32'(1));
        void'(exp0.pop_back());
        void'(exp1.pop_back());
        cmp_writes("abort");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        words = '{16'hBEEF};
        build();
        send_stream(0);
        wait_done("restart");
        cmp_writes("restart");

`ifdef BOOT_CHECKSUM_EN
        // Checksum mismatch parks in ERR
        do_reset();
        words = '{16'h0001, 16'h0002};
        build();
        bq[bq.size() - 1] = 8'h04;
        cpu_we = 1'b1;
        send_stream(0);
        repeat (3) @(posedge clk);
        #1;
        check("err_flag", 32'(err0), 32'(1));
        check("err_hold", 32'(cpu_hold0), 32'(1));
        check("err_done", 32'(done0), 32'(0));
        check("err_ready", 32'(rx_ready0), 32'(0));
        check("err_we", 32'(sram_we0), 32'(0));
        cmp_writes("err");
        cpu_we = 1'b0;
`endif

        // Randomized loads with random source gaps
        for (int it = 0; it < 8; it++) begin
            int n;
            do_reset();
            n = (it == 0) ? 0 : int'($urandom_range(1, 10));
            words.delete();
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            build();
            send_stream(2);
            wait_done("rand");
            check("rand_err", 32'(err0), 32'(0));
            cmp_writes("rand");
            cpu_addr = 12'($urandom); cpu_din = 16'($urandom); cpu_we = 1'($urandom);
            #1;
            check("rand_pt_addr", 32'(sram_addr0), 32'(cpu_addr));
            check("rand_pt_din", 32'(sram_din1), 32'(cpu_din));
            check("rand_pt_we", 32'(sram_we0), 32'(cpu_we));
            cpu_we = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Program loader and memory-port mux between the CPU and the SRAM. After reset it holds the CPU, receives a byte stream over a valid/ready handshake, packs the bytes into 16-bit words and writes them to consecutive SRAM addresses. When the load is complete it releases the CPU and passes the CPU's SRAM port straight through to the SRAM.

## Interface
Parameters:
- ADDR_W, 12, SRAM word-address width
- BASE_ADDR, 0, SRAM address of the first loaded word

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle
- cpu_addr  in  ADDR_W  CPU SRAM address
- cpu_din  in  16  CPU write data
- cpu_we  in  1  CPU write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_din  out  16  SRAM write data
- sram_we  out  1  SRAM write enable
- cpu_hold  out  1  CPU must stall while this is 1
- done  out  1  load complete, port passed through
- err  out  1  checksum failure (tied to 0 without BOOT_CHECKSUM_EN)

## Operation
- Byte accept: a byte is accepted on a rising edge where rx_valid && rx_ready.
- Byte order: big-endian; the high byte comes first.
- FSM states: HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, CHK_HI, CHK_LO, DONE, ERR.
- Frame format: a 16-bit header word N (the data word count), then N data words.
- Header: HDR_HI → HDR_LO → DATA_HI. If N == 0, HDR_LO goes to DONE instead (or to CHK_HI when the macro is on).
- Data: DATA_HI → DATA_LO → WRITE (one cycle). After WRITE:
  - go back to DATA_HI if words remain;
  - otherwise go to DONE (or CHK_HI when the macro is on).
- WRITE cycle drives:
  - sram_we = 1;
  - sram_addr = (BASE_ADDR + idx) mod 2^ADDR_W, where idx is the 16-bit word index starting at 0;
  - sram_din = the assembled word.
- Address wrap: addresses wrap modulo 2^ADDR_W. N larger than 2^ADDR_W overwrites earlier words; this is not an error.
- Load phase (every state except DONE): cpu_we, cpu_addr and cpu_din are ignored; sram_we is 1 only in WRITE.
- DONE: sram_addr, sram_din and sram_we equal cpu_addr, cpu_din and cpu_we combinationally. cpu_hold = 0, done = 1, rx_ready = 0. The state is terminal until reset.
- rx_ready is 1 in HDR_*, DATA_* and CHK_*, and 0 in WRITE, DONE and ERR. It is additionally gated by an enable flop that resets to 0 and sets on the first clock after rst deasserts.

## Timing
- Reset values, asynchronous while rst = 0:
  - state = HDR_HI, idx = 0, N = 0;
  - rx_ready = 0, sram_we = 0, cpu_hold = 1, done = 0, err = 0;
  - sram_addr = 0, sram_din = 0.
- Reset mid-load aborts at once: sram_we drops without waiting for a clock edge. Words already written stay in SRAM; loading restarts at HDR_HI.
- Latency: sram_we is asserted in the cycle immediately after the edge that accepts the low data byte.
- Throughput: at most one word per 3 cycles with rx_valid held at 1.
- Backpressure: a byte presented during WRITE is not accepted. The source holds it, and it is accepted on the next cycle.
- Release:
  - last data word, macro off: cpu_hold falls and done rises on the clock edge that ends the last WRITE;
  - N == 0, macro off: they change on the edge that accepts the header low byte.
  - macro on: they change on the edge that accepts the checksum low byte, if the checksum matches.

## Configuration
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - A 16-bit checksum register clears at reset and accumulates the sum of all data words modulo 2^16; the header is not included.
  - After the last data word (or directly after the header when N == 0), two checksum bytes follow in CHK_HI → CHK_LO.
  - Match → DONE.
  - Mismatch → ERR: err = 1, cpu_hold = 1, done = 0, rx_ready = 0, sram_we = 0. ERR is held until reset.
- Undefined: the CHK_* and ERR states are not built and err is tied to 0.

## Test plan
- Basic load, BASE_ADDR = 0, stream 00 03 12 34 AB CD 00 01:
  - writes 0x1234@0x000, 0xABCD@0x001, 0x0001@0x002, one sram_we pulse each;
  - done rises after the third write.
- Empty load, stream 00 00: no sram_we pulse; cpu_hold = 0 on the edge accepting the second byte.
- Wrap, BASE_ADDR = 0xFFE, N = 3: writes go to 0xFFE, 0xFFF, 0x000.
- Gappy source with rx_valid toggling every cycle: rx_ready = 0 in each WRITE cycle; no byte is lost or duplicated; the SRAM image matches the stream.
- Pass-through:
  - before done, cpu_we = 1, cpu_addr = 0x0A5 → sram_we stays 0;
  - after done, cpu_we = 1, cpu_addr = 0x0A5, cpu_din = 0x5A5A → same-cycle sram_we = 1, sram_addr = 0x0A5, sram_din = 0x5A5A.
- Reset mid-load after one word → sram_we = 0 immediately; a fresh stream 00 01 BE EF then writes 0xBEEF@BASE_ADDR.
- With BOOT_CHECKSUM_EN, stream 00 02 00 01 00 02:
  - trailer 00 03 → done = 1;
  - trailer 00 04 → err = 1, cpu_hold = 1, rx_ready = 0.
